// File: rtl/ale_defs_pkg.sv
// Shared defaults and helpers for the atmospheric light estimator family.
// Default geometry, A scaling constants and the pixel/channel bit-offset helper live here.
package ale_defs;

    localparam int ALE_DW          = 8;
    localparam int ALE_CH          = 3;
    localparam int ALE_WIN         = 3;
    localparam int ALE_INV_W       = 16;
    localparam int ALE_SCALE_NUM   = 7;
    localparam int ALE_SCALE_SHIFT = 3;
    localparam int ALE_SMOOTH_SH   = 2;

    // Frame control states; COMMIT is held for exactly one cycle per eof.
    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    // LSB of channel c of pixel p; pixel 0 sits at the bottom, channel 0 at the top of each pixel.
    function automatic int chan_lsb(input int p, input int c, input int ch, input int dw);
        return p * ch * dw + (ch - 1 - c) * dw;
    endfunction

endpackage

// File: rtl/ale_reciprocal.sv
// Saturating Q0.INV_W reciprocal: inv = min(2**INV_W / a, 2**INV_W - 1), a = 0 saturates.
// Purely combinational; one instance per channel.
module ale_reciprocal
    import ale_defs::*;
#(
    parameter int DW    = ALE_DW,
    parameter int INV_W = ALE_INV_W
) (
    input  logic [DW-1:0]    a,
    output logic [INV_W-1:0] inv
);
    localparam logic [INV_W:0]   NUM     = {1'b1, {INV_W{1'b0}}};
    localparam logic [INV_W-1:0] INV_SAT = {INV_W{1'b1}};

    logic [INV_W:0] quot;

    always_comb begin
        quot = '0;
        if (a != '0) begin
            quot = NUM / (INV_W+1)'(a);
        end
        // Only a == 1 produces a quotient that overflows INV_W bits.
        inv = (a == '0 || quot[INV_W]) ? INV_SAT : quot[INV_W-1:0];
    end

endmodule

// File: rtl/ale_frame_estimator.sv
// Per-frame atmospheric light estimator: keeps the window with the largest dark channel and commits A, 1/A.
// Build option: define ALE_TEMPORAL_SMOOTH_EN to IIR-smooth A across frames (one extra cycle of latency).
module ale_frame_estimator
    import ale_defs::*;
#(
    parameter int DW          = ALE_DW,
    parameter int CH          = ALE_CH,
    parameter int WIN         = ALE_WIN,
    parameter int SCALE_NUM   = ALE_SCALE_NUM,
    parameter int SCALE_SHIFT = ALE_SCALE_SHIFT,
    parameter int INV_W       = ALE_INV_W,
    parameter int SMOOTH_SH   = ALE_SMOOTH_SH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     in_eof,
    input  logic [WIN*WIN*CH*DW-1:0] in_window,
    output logic [CH*DW-1:0]         out_A,
    output logic [CH*INV_W-1:0]      out_inv_A,
    output logic [DW-1:0]            out_dc_max,
    output logic                     out_valid
);
    localparam int NPIX = WIN * WIN;
    localparam int PW   = DW + SCALE_SHIFT;

    genvar gi;

    logic [CH*DW-1:0]    win_min;
    logic [CH*DW-1:0]    s1_min_reg;
    logic                s1_valid_reg, s1_sof_reg, s1_eof_reg;
    logic [CH*DW-1:0]    beat_a;
    logic [DW-1:0]       beat_dc;
    logic [DW-1:0]       run_max_reg, run_max_next;
    logic [CH*DW-1:0]    cand_reg, cand_next;
    logic [CH*DW-1:0]    snap_a_reg;
    logic [DW-1:0]       snap_dc_reg;
    logic [0:0]          state_reg;
    logic                commit_now;
    logic                out_load;
    logic [CH*DW-1:0]    rcp_a;
    logic [DW-1:0]       rcp_dc;
    logic [CH*INV_W-1:0] rcp_inv;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            logic [DW-1:0] ch_min;
            logic [PW-1:0] prod;

            always_comb begin
                ch_min = '1;
                for (int p = 0; p < NPIX; p++) begin
                    if (in_window[chan_lsb(p, gi, CH, DW) +: DW] < ch_min) begin
                        ch_min = in_window[chan_lsb(p, gi, CH, DW) +: DW];
                    end
                end
            end

            assign win_min[(CH-1-gi)*DW +: DW] = ch_min;
            assign prod = PW'(s1_min_reg[(CH-1-gi)*DW +: DW]) * PW'(SCALE_NUM);
            assign beat_a[(CH-1-gi)*DW +: DW] = DW'(prod >> SCALE_SHIFT);
        end
    endgenerate

    always_comb begin
        beat_dc = s1_min_reg[(CH-1)*DW +: DW];
        for (int c = 1; c < CH; c++) begin
            if (s1_min_reg[(CH-1-c)*DW +: DW] < beat_dc) begin
                beat_dc = s1_min_reg[(CH-1-c)*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_min_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s1_sof_reg   <= 1'b0;
            s1_eof_reg   <= 1'b0;
        end else begin
            s1_min_reg   <= win_min;
            s1_valid_reg <= in_valid;
            s1_sof_reg   <= in_valid && in_sof;
            s1_eof_reg   <= in_valid && in_eof;
        end
    end

    // sof reloads unconditionally; otherwise only a strictly larger dark channel wins, so ties keep the earlier window.
    always_comb begin
        run_max_next = run_max_reg;
        cand_next    = cand_reg;
        if (s1_valid_reg && (s1_sof_reg || beat_dc > run_max_reg)) begin
            run_max_next = beat_dc;
            cand_next    = beat_a;
        end
    end

    assign commit_now = s1_valid_reg && s1_eof_reg;

    // Back-to-back eofs simply re-enter COMMIT; the snapshot is consumed on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max_reg <= '0;
            cand_reg    <= '0;
            snap_a_reg  <= '0;
            snap_dc_reg <= '0;
            state_reg   <= ST_ACCUM;
        end else begin
            run_max_reg <= commit_now ? '0 : run_max_next;
            cand_reg    <= commit_now ? '0 : cand_next;
            if (commit_now) begin
                snap_a_reg  <= cand_next;
                snap_dc_reg <= run_max_next;
            end
            state_reg <= commit_now ? ST_COMMIT : ST_ACCUM;
        end
    end

`ifdef ALE_TEMPORAL_SMOOTH_EN
    localparam int SW = DW + SMOOTH_SH;

    logic [CH*DW-1:0] sm_a_reg, sm_a_next;
    logic [DW-1:0]    sm_dc_reg;
    logic             sm_valid_reg, first_done_reg;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_smooth
            logic [SW-1:0] acc;

            assign acc = SW'(sm_a_reg[(CH-1-gi)*DW +: DW]) * SW'((1 << SMOOTH_SH) - 1)
                       + SW'(snap_a_reg[(CH-1-gi)*DW +: DW]);
            assign sm_a_next[(CH-1-gi)*DW +: DW] = first_done_reg ? DW'(acc >> SMOOTH_SH)
                                                                  : snap_a_reg[(CH-1-gi)*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sm_a_reg       <= '0;
            sm_dc_reg      <= '0;
            sm_valid_reg   <= 1'b0;
            first_done_reg <= 1'b0;
        end else begin
            sm_valid_reg <= (state_reg == ST_COMMIT);
            if (state_reg == ST_COMMIT) begin
                sm_a_reg       <= sm_a_next;
                sm_dc_reg      <= snap_dc_reg;
                first_done_reg <= 1'b1;
            end
        end
    end

    assign out_load = sm_valid_reg;
    assign rcp_a    = sm_a_reg;
    assign rcp_dc   = sm_dc_reg;
`else
    assign out_load = (state_reg == ST_COMMIT);
    assign rcp_a    = snap_a_reg;
    assign rcp_dc   = snap_dc_reg;
`endif

    generate
        for (gi = 0; gi < CH; gi++) begin : g_rcp
            ale_reciprocal #(
                .DW    (DW),
                .INV_W (INV_W)
            ) u_rcp (
                .a   (rcp_a[(CH-1-gi)*DW +: DW]),
                .inv (rcp_inv[(CH-1-gi)*INV_W +: INV_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_A      <= '0;
            out_inv_A  <= '0;
            out_dc_max <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= out_load;
            if (out_load) begin
                out_A      <= rcp_a;
                out_inv_A  <= rcp_inv;
                out_dc_max <= rcp_dc;
            end
        end
    end

endmodule
